// File: rtl/park_gate_arbiter_if.sv
// Park gate arbiter bus: lane requests, sensor and gate status.
// master drives requests and the lane sensor; slave is the arbiter.
interface park_gate_arbiter_if;
    logic       ReqIn;
    logic       ReqOut;
    logic       Pass;
    logic       GntIn;
    logic       GntOut;
    logic       GateOpen;
    logic [3:0] CarCount;
    logic       Full;
    logic       Empty;
    logic       Timeout;

    modport master (
        output ReqIn, ReqOut, Pass,
        input  GntIn, GntOut, GateOpen, CarCount, Full, Empty, Timeout
    );

    modport slave (
        input  ReqIn, ReqOut, Pass,
        output GntIn, GntOut, GateOpen, CarCount, Full, Empty, Timeout
    );
endinterface

// File: rtl/park_gate_arbiter.sv
// Single-lane car park gate arbiter with occupancy counter.
// Round-robin between entry and exit, abandoned grants time out.
module park_gate_arbiter #(
    parameter int CAPACITY = 15,
    parameter int TIMEOUT  = 255
) (
    input logic                Clk,
    input logic                Reset,
    park_gate_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        OPEN_IN,
        OPEN_OUT,
        CLEAR_IN,
        CLEAR_OUT
    } state_t;

    localparam logic [3:0] CAP      = 4'(CAPACITY);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic [3:0] car_cnt, car_nxt;
    logic       last_out, last_out_nxt;
    logic       timeout_nxt;
    logic       gnt_in_q, gnt_out_q, open_q, timeout_q;
    logic       full, empty;
    logic       elig_in, elig_out;

    assign full     = (car_cnt == CAP);
    assign empty    = (car_cnt == 4'd0);
    assign elig_in  = bus.ReqIn && !full;
    assign elig_out = bus.ReqOut && !empty;

    // Next-state, wait timer, occupancy and round-robin decisions.
    always_comb begin
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        car_nxt      = car_cnt;
        last_out_nxt = last_out;
        timeout_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                wait_nxt = '0;
                if (elig_in && (!elig_out || last_out)) begin
                    state_nxt    = OPEN_IN;
                    last_out_nxt = 1'b0;
                end else if (elig_out) begin
                    state_nxt    = OPEN_OUT;
                    last_out_nxt = 1'b1;
                end
            end
            OPEN_IN, OPEN_OUT: begin
                if (bus.Pass) begin
                    state_nxt = (state == OPEN_IN) ? CLEAR_IN : CLEAR_OUT;
                    wait_nxt  = '0;
                end else if (wait_cnt == TMO_LAST) begin
                    state_nxt   = IDLE;
                    wait_nxt    = '0;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            CLEAR_IN: begin
                if (!bus.Pass) begin
                    state_nxt = IDLE;
                    if (car_cnt < CAP) car_nxt = car_cnt + 4'd1;
                end
            end
            CLEAR_OUT: begin
                if (!bus.Pass) begin
                    state_nxt = IDLE;
                    if (car_cnt != 4'd0) car_nxt = car_cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            car_cnt   <= '0;
            last_out  <= 1'b1;
            gnt_in_q  <= 1'b0;
            gnt_out_q <= 1'b0;
            open_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            car_cnt   <= car_nxt;
            last_out  <= last_out_nxt;
            gnt_in_q  <= (state_nxt == OPEN_IN) || (state_nxt == CLEAR_IN);
            gnt_out_q <= (state_nxt == OPEN_OUT) || (state_nxt == CLEAR_OUT);
            open_q    <= (state_nxt != IDLE);
            timeout_q <= timeout_nxt;
        end
    end

    assign bus.GntIn    = gnt_in_q;
    assign bus.GntOut   = gnt_out_q;
    assign bus.GateOpen = open_q;
    assign bus.Timeout  = timeout_q;
    assign bus.CarCount = car_cnt;
    assign bus.Full     = full;
    assign bus.Empty    = empty;
endmodule

// File: tb/tb_park_gate_arbiter.sv
// Bench for park_gate_arbiter: directed scenarios then random traffic
// compared cycle by cycle against a transaction-level gate model.
module tb_park_gate_arbiter;
    localparam int CAP = 15;
    localparam int TMO = 10;

    logic Clk;
    logic Reset;
    int   total;
    int   bad;

    park_gate_arbiter_if bus ();

    park_gate_arbiter #(
        .CAPACITY(CAP),
        .TIMEOUT (TMO)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: who owns the gate, whether a car is in the lane,
    // how long the owner has waited, occupancy and who was served last.
    int owner;
    bit in_lane;
    int waited;
    int occ;
    int prev;
    bit exp_to;

    function automatic void model_reset();
        owner   = -1;
        in_lane = 1'b0;
        waited  = 0;
        occ     = 0;
        prev    = 1;
        exp_to  = 1'b0;
    endfunction

    function automatic void model_step(bit rin, bit rout, bit pas);
        bit ein;
        bit eout;
        exp_to = 1'b0;
        if (owner < 0) begin
            ein  = rin && (occ < CAP);
            eout = rout && (occ > 0);
            if (ein && eout) owner = (prev == 1) ? 0 : 1;
            else if (ein) owner = 0;
            else if (eout) owner = 1;
            if (owner >= 0) begin
                prev    = owner;
                waited  = 0;
                in_lane = 1'b0;
            end
        end else if (!in_lane) begin
            if (pas) begin
                in_lane = 1'b1;
            end else begin
                waited++;
                if (waited == TMO) begin
                    owner  = -1;
                    exp_to = 1'b1;
                end
            end
        end else if (!pas) begin
            if (owner == 0 && occ < CAP) occ++;
            else if (owner == 1 && occ > 0) occ--;
            owner   = -1;
            in_lane = 1'b0;
        end
    endfunction

    function automatic int exp_vec();
        logic [9:0] v;
        v = {owner == 0, owner == 1, owner >= 0, exp_to,
             occ == CAP, occ == 0, 4'(occ)};
        return int'(v);
    endfunction

    function automatic int obs_vec();
        logic [9:0] v;
        v = {bus.GntIn, bus.GntOut, bus.GateOpen, bus.Timeout,
             bus.Full, bus.Empty, bus.CarCount};
        return int'(v);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step(bus.ReqIn, bus.ReqOut, bus.Pass);
        @(posedge Clk);
        #1;
        chk("model", obs_vec(), exp_vec());
    endtask

    task automatic do_pass(input logic ri, input logic ro, output logic dir);
        int n;
        bus.ReqIn  = ri;
        bus.ReqOut = ro;
        n = 0;
        while (!(bus.GntIn || bus.GntOut) && n < 4) begin
            tick();
            n++;
        end
        chk("grant_wait", int'(bus.GntIn || bus.GntOut), 1);
        dir = bus.GntOut;
        bus.Pass = 1'b1;
        tick();
        tick();
        bus.Pass = 1'b0;
        tick();
    endtask

    initial begin
        logic       d;
        logic [2:0] order;
        int         n;
        bit         granted;

        total      = 0;
        bad        = 0;
        Reset      = 1'b0;
        bus.ReqIn  = 1'b0;
        bus.ReqOut = 1'b0;
        bus.Pass   = 1'b0;
        model_reset();

        #3;
        chk("reset_state", obs_vec(), 'h010);
        #9 Reset = 1'b1;
        @(posedge Clk);
        #1;

        // Single entry: grant one cycle after the request.
        bus.ReqIn = 1'b1;
        tick();
        chk("entry_gnt", int'({bus.GntIn, bus.GntOut, bus.GateOpen}), 'b101);
        bus.ReqIn = 1'b0;
        bus.Pass  = 1'b1;
        repeat (3) tick();
        bus.Pass = 1'b0;
        tick();
        chk("entry_count", int'(bus.CarCount), 1);
        chk("entry_empty", int'(bus.Empty), 0);

        // Reach two cars with exit served last, then a held tie.
        do_pass(1'b1, 1'b0, d);
        do_pass(1'b1, 1'b0, d);
        do_pass(1'b0, 1'b1, d);
        chk("tie_pre_count", int'(bus.CarCount), 2);
        for (int i = 0; i < 3; i++) begin
            do_pass(1'b1, 1'b1, d);
            order[2-i] = d;
        end
        bus.ReqIn  = 1'b0;
        bus.ReqOut = 1'b0;
        chk("tie_order", int'(order), 'b010);
        chk("tie_count", int'(bus.CarCount), 3);

        // Abandoned grant.
        bus.ReqIn = 1'b1;
        tick();
        chk("to_gnt", int'(bus.GntIn), 1);
        bus.ReqIn = 1'b0;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.Timeout) break;
            n += int'(bus.GateOpen);
        end
        chk("to_open_cycles", n, TMO);
        chk("to_pulse", int'({bus.Timeout, bus.GateOpen}), 'b10);
        chk("to_count", int'(bus.CarCount), 3);
        tick();
        chk("to_one_pulse", int'(bus.Timeout), 0);

        // Drain, then an exit request on an empty park.
        repeat (3) do_pass(1'b0, 1'b1, d);
        bus.ReqIn  = 1'b0;
        bus.ReqOut = 1'b1;
        granted = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.GntOut || bus.GateOpen) granted = 1'b1;
        end
        chk("empty_no_gnt", int'(granted), 0);
        chk("empty_flags", int'({bus.Empty, bus.CarCount}), 'h10);
        bus.ReqOut = 1'b0;

        // Fill to capacity, then entry must be refused.
        repeat (CAP) do_pass(1'b1, 1'b0, d);
        chk("full_count", int'({bus.Full, bus.CarCount}), 'h1F);
        bus.ReqIn = 1'b1;
        granted = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.GntIn || bus.GateOpen) granted = 1'b1;
        end
        chk("full_no_gnt", int'(granted), 0);
        do_pass(1'b1, 1'b1, d);
        chk("full_exit_dir", int'(d), 1);
        chk("full_exit_count", int'({bus.Full, bus.CarCount}), 'h0E);
        bus.ReqOut = 1'b0;
        tick();
        chk("full_in_next", int'(bus.GntIn), 1);
        bus.ReqIn = 1'b0;
        bus.Pass  = 1'b1;
        tick();
        bus.Pass = 1'b0;
        tick();
        chk("refill", int'(bus.CarCount), CAP);

        // Reset in the middle of a passage with five cars inside.
        Reset = 1'b0;
        #3;
        model_reset();
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        repeat (5) do_pass(1'b1, 1'b0, d);
        bus.ReqIn = 1'b1;
        tick();
        bus.ReqIn = 1'b0;
        bus.Pass  = 1'b1;
        tick();
        chk("mid_pre", int'({bus.GntIn, bus.GateOpen, bus.CarCount}), 'h35);
        #3 Reset = 1'b0;
        #1;
        chk("mid_async", obs_vec(), 'h010);
        model_reset();
        bus.Pass = 1'b0;
        #2 Reset = 1'b1;
        repeat (2) tick();
        chk("mid_no_count", int'(bus.CarCount), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.ReqIn  = 1'($urandom_range(0, 1));
            bus.ReqOut = 1'($urandom_range(0, 1));
            if (bus.Pass) bus.Pass = ($urandom_range(0, 2) != 0);
            else bus.Pass = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/park_gate_arbiter.md
PARK_GATE_ARBITER -- requirements
Module: park_gate_arbiter

Interface
REQ-001 Parameter CAPACITY, default 15; maximum number of cars allowed inside. It SHALL satisfy 1 <= CAPACITY <= 15.
REQ-002 Parameter TIMEOUT, default 255; number of cycles an open gate waits for a car before closing. It SHALL satisfy 1 <= TIMEOUT <= 255.
REQ-003 Clk, input, 1; the single clock, rising-edge active.
REQ-004 Reset, input, 1; asynchronous, active-low reset (Reset=0 resets the block).
REQ-005 ReqIn, input, 1; an entry car is waiting at the shared single-lane gate.
REQ-006 ReqOut, input, 1; an exit car is waiting at the shared single-lane gate.
REQ-007 Pass, input, 1; lane sensor, 1 while a car occupies the gate lane.
REQ-008 GntIn, output, 1; the entry direction currently owns the gate.
REQ-009 GntOut, output, 1; the exit direction currently owns the gate.
REQ-010 GateOpen, output, 1; barrier open command.
REQ-011 CarCount, output, 4; current occupancy.
REQ-012 Full, output, 1; asserted when CarCount == CAPACITY.
REQ-013 Empty, output, 1; asserted when CarCount == 0.
REQ-014 Timeout, output, 1; one-cycle pulse when a grant is abandoned.

Function
REQ-015 All outputs SHALL be registered. Full and Empty SHALL be decoded from the registered CarCount.
REQ-016 The FSM SHALL have the states IDLE, OPEN_IN, OPEN_OUT, CLEAR_IN and CLEAR_OUT.
REQ-017 A request SHALL be eligible as follows: ReqIn only when Full=0; ReqOut only when Empty=0.
REQ-018 IDLE with exactly one eligible request SHALL move to OPEN_IN or OPEN_OUT on the next edge. Grant latency SHALL be 1 cycle.
REQ-019 IDLE with both requests eligible SHALL grant round-robin: the direction not served last wins. The last-served flag SHALL reset to "out", so the first tie goes to entry.
REQ-020 The last-served flag SHALL update on every grant, including grants that later time out.
REQ-021 An ineligible request SHALL be ignored. In particular, ReqIn while Full=1 SHALL never be granted, even when it is the only request.
REQ-022 In OPEN_x and CLEAR_x, GateOpen SHALL be 1 and the matching Gnt SHALL be 1. The other Gnt SHALL be 0. In IDLE, GateOpen, GntIn and GntOut SHALL all be 0.
REQ-023 OPEN_x with Pass=1 SHALL move to CLEAR_x.
REQ-024 OPEN_x SHALL use an 8-bit wait timer, cleared on entry to the state.
REQ-025 If Pass stays 0 for TIMEOUT consecutive cycles in OPEN_x, the FSM SHALL return to IDLE, pulse Timeout for 1 cycle and leave CarCount unchanged.
REQ-026 CLEAR_x with Pass=0 SHALL return to IDLE. CarCount SHALL increment (CLEAR_IN) or decrement (CLEAR_OUT) on that same edge.
REQ-027 CLEAR_x SHALL have no timeout; the gate stays open while the lane is occupied.
REQ-028 CarCount SHALL never exceed CAPACITY nor wrap below 0. Saturation guards SHALL exist in addition to the eligibility rules.
REQ-029 Requests arriving outside IDLE SHALL be held off and not lost. They are re-evaluated on the first IDLE cycle.
REQ-030 Both directions are never granted together. After a completed or abandoned grant, the gate SHALL spend at least one cycle in IDLE.
REQ-031 A change on ReqIn or ReqOut after a grant SHALL not affect the current grant.

Reset
REQ-032 While Reset=0, the outputs SHALL be: state IDLE, CarCount=0, Empty=1, Full=0, GateOpen=0, GntIn=0, GntOut=0, Timeout=0, wait timer=0, last-served="out". This SHALL apply asynchronously, even in the middle of a grant.
REQ-033 An interrupted passage SHALL not be counted.
REQ-034 After Reset rises, operation SHALL resume at the first rising Clk edge.

Verification
REQ-035 Single entry: after reset, ReqIn=1, then Pass=1 for 3 cycles, then Pass=0 -> GntIn and GateOpen=1 one cycle after ReqIn; CarCount=1 after Pass falls; Empty=0.
REQ-036 Tie: with CarCount=2, ReqIn=ReqOut=1 held through 3 complete passages -> grants go in, out, in; final CarCount=3.
REQ-037 Full: CAPACITY=15 and CarCount=15, ReqIn=1 for 20 cycles -> no grant and Full=1. Then ReqOut=1 with a full Pass pulse -> CarCount=14, Full=0, and ReqIn is granted next.
REQ-038 Timeout: TIMEOUT=10, ReqIn=1, Pass held 0 -> GateOpen=1 for 10 cycles, then Timeout pulses once, IDLE, CarCount unchanged.
REQ-039 Empty exit: CarCount=0, ReqOut=1 -> never granted, Empty=1, CarCount=0.
REQ-040 Reset mid-passage: in CLEAR_IN with CarCount=5, drive Reset=0 between clock edges -> outputs reset immediately, CarCount=0, and no increment occurs.
